// File: rtl/ifmap_stage_buffer.sv
// Stages one ifmap tile (COL_NUM columns x DEPTH elements), then drains it to the PE array, aligned or column-skewed.
// Drain data appears the cycle after drain_start is sampled in FULL; load_ready is low in FULL/DRAIN, which stalls the loader.
module ifmap_stage_buffer #(
    parameter int COL_NUM = 32,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [DEPTH*DATA_W-1:0]     load_data,
    input  logic                        load_last,
    input  logic                        drain_start,
    input  logic                        skew_mode,
    output logic [COL_NUM*DATA_W-1:0]   ifmap_out,
    output logic [COL_NUM-1:0]          out_valid,
    output logic                        busy,
    output logic                        drain_done
);

    localparam int WORD_W = DEPTH * DATA_W;
    localparam int IDX_W  = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam int PTR_W  = $clog2(COL_NUM + 1);
    localparam int CNT_W  = $clog2(DEPTH + COL_NUM);
    localparam logic [CNT_W-1:0] LAST_T_ALIGN = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_T_SKEW  = CNT_W'(DEPTH + COL_NUM - 2);
    localparam logic [PTR_W-1:0] LAST_COL     = PTR_W'(COL_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WORD_W-1:0]  r_mem [COL_NUM];
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_t;
    logic               r_skew;

    logic w_xfer;
    logic w_last_col;
    logic w_fill_end;
    logic w_drain_end;

    assign w_xfer      = load_valid & load_ready;
    assign w_last_col  = (r_state == S_IDLE) ? (COL_NUM == 1) : (r_ptr == LAST_COL);
    assign w_fill_end  = load_last | w_last_col;
    assign w_drain_end = (r_state == S_DRAIN) && (r_t == (r_skew ? LAST_T_SKEW : LAST_T_ALIGN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_next = w_fill_end ? S_FULL : S_LOAD;
            S_LOAD:  if (w_xfer && w_fill_end) w_next = S_FULL;
            S_FULL:  if (drain_start) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_comb begin
        load_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
        busy       = (r_state != S_IDLE);
        drain_done = w_drain_end;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < COL_NUM; c++) r_mem[c] <= '0;
            r_ptr  <= '0;
            r_t    <= '0;
            r_skew <= 1'b0;
        end else if (flush) begin
            for (int c = 0; c < COL_NUM; c++) r_mem[c] <= '0;
            r_ptr  <= '0;
            r_t    <= '0;
            r_skew <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_xfer) begin
                    // a new tile starts from a clean slate so short tiles leave zero columns
                    for (int c = 0; c < COL_NUM; c++) r_mem[c] <= (c == 0) ? load_data : '0;
                    r_ptr <= PTR_W'(1);
                end
                S_LOAD: if (w_xfer) begin
                    r_mem[r_ptr[IDX_W-1:0]] <= load_data;
                    r_ptr <= r_ptr + PTR_W'(1);
                end
                S_FULL: if (drain_start) begin
                    r_skew <= skew_mode;
                    r_t    <= '0;
                end
                S_DRAIN: if (w_drain_end) begin
                    for (int c = 0; c < COL_NUM; c++) r_mem[c] <= '0;
                    r_ptr <= '0;
                    r_t   <= '0;
                end else begin
                    r_t <= r_t + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // column c shows element t - c when skewed, t when aligned
    always_comb begin
        ifmap_out = '0;
        out_valid = '0;
        if (r_state == S_DRAIN) begin
            for (int c = 0; c < COL_NUM; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (int'(r_t) - (r_skew ? c : 0) == k) begin
                        out_valid[c] = 1'b1;
                        ifmap_out[c*DATA_W +: DATA_W] = r_mem[c][k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ifmap_stage_buffer.sv
// Randomized bench: tiles are kept as plain arrays and each drain cycle's output is computed from the element-index rule.
module tb_ifmap_stage_buffer;

    localparam int COL_NUM = 32;
    localparam int DEPTH   = 4;
    localparam int DATA_W  = 8;
    localparam int WORD_W  = DEPTH * DATA_W;
    localparam int OUT_W   = COL_NUM * DATA_W;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                flush = 1'b0;
    logic                load_valid = 1'b0;
    logic                load_ready;
    logic [WORD_W-1:0]   load_data = '0;
    logic                load_last = 1'b0;
    logic                drain_start = 1'b0;
    logic                skew_mode = 1'b0;
    logic [OUT_W-1:0]    ifmap_out;
    logic [COL_NUM-1:0]  out_valid;
    logic                busy;
    logic                drain_done;

    logic [WORD_W-1:0]   tile [COL_NUM];
    int                  n_chk = 0;
    int                  n_pass = 0;

    always #5 clk = ~clk;

    ifmap_stage_buffer #(.COL_NUM(COL_NUM), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .drain_start(drain_start), .skew_mode(skew_mode),
        .ifmap_out(ifmap_out), .out_valid(out_valid), .busy(busy), .drain_done(drain_done)
    );

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, load_ready, 1);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_dat"}, ifmap_out, 0);
        chk({tag, "_done"}, drain_done, 0);
    endtask

    task automatic load_tile(input int n, input bit use_last, input bit gaps, input bit ramp);
        for (int c = 0; c < COL_NUM; c++) tile[c] = '0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    load_valid  = 1'b0;
                    load_data   = $urandom;
                    load_last   = 1'($urandom_range(0, 1));
                    drain_start = 1'($urandom_range(0, 1));
                    step();
                end
            end
            if (ramp) for (int k = 0; k < DEPTH; k++) tile[i][k*DATA_W +: DATA_W] = 8'(i*4 + k);
            else      tile[i] = $urandom;
            load_valid  = 1'b1;
            load_data   = tile[i];
            load_last   = use_last && (i == n - 1);
            drain_start = 1'($urandom_range(0, 1));
            chk("load_rdy", load_ready, 1);
            step();
        end
        load_valid  = 1'b0;
        load_last   = 1'b0;
        drain_start = 1'b0;
        chk("full_rdy", load_ready, 0);
        chk("full_busy", busy, 1);
        chk("full_ov", out_valid, 0);
        // words offered while full must be refused and leave the tile untouched
        repeat ($urandom_range(1, 3)) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            step();
            chk("hold_rdy", load_ready, 0);
            chk("hold_ov", out_valid, 0);
        end
        load_valid = 1'b0;
    endtask

    task automatic drain_tile(input bit skew, input int flush_at);
        int len;
        logic [OUT_W-1:0]   ed;
        logic [COL_NUM-1:0] ev;
        len = skew ? DEPTH + COL_NUM - 1 : DEPTH;
        drain_start = 1'b1;
        skew_mode   = skew;
        step();
        drain_start = 1'b0;
        for (int t = 0; t < len; t++) begin
            skew_mode   = 1'($urandom_range(0, 1));
            drain_start = 1'($urandom_range(0, 1));
            ed = '0;
            ev = '0;
            for (int c = 0; c < COL_NUM; c++) begin
                int k;
                k = t - (skew ? c : 0);
                if (k >= 0 && k < DEPTH) begin
                    ev[c] = 1'b1;
                    ed[c*DATA_W +: DATA_W] = tile[c][k*DATA_W +: DATA_W];
                end
            end
            chk("drain_busy", busy, 1);
            chk("drain_vld", out_valid, ev);
            chk("drain_dat", ifmap_out, ed);
            chk("drain_done", drain_done, (t == len - 1) ? 1 : 0);
            if (t == flush_at) begin
                flush = 1'b1;
                step();
                flush       = 1'b0;
                drain_start = 1'b0;
                check_idle("flush_drain");
                return;
            end
            step();
        end
        drain_start = 1'b0;
        check_idle("post_drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  lst;
        #3;
        check_idle("rst");
        @(negedge clk);
        reset = 1'b1;
        step();
        check_idle("rst_rel");

        load_tile(COL_NUM, 1'b0, 1'b0, 1'b1);
        drain_tile(1'b0, -1);
        load_tile(COL_NUM, 1'b0, 1'b1, 1'b1);
        drain_tile(1'b1, -1);
        load_tile(3, 1'b1, 1'b1, 1'b0);
        drain_tile(1'b0, -1);

        // drain_start while loading is ignored; flush then drops the partial tile and a concurrent word
        load_valid = 1'b1;
        load_data  = $urandom;
        repeat (2) step();
        load_valid  = 1'b0;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        chk("ld_ds_busy", busy, 1);
        chk("ld_ds_rdy", load_ready, 1);
        chk("ld_ds_ov", out_valid, 0);
        load_valid = 1'b1;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        load_valid = 1'b0;
        check_idle("flush_load");

        load_tile(COL_NUM, 1'b0, 1'b0, 1'b0);
        drain_tile(1'b0, 2);

        load_valid = 1'b1;
        load_data  = $urandom;
        repeat (5) step();
        load_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_idle("arst_load");
        @(negedge clk);
        reset = 1'b1;
        step();
        load_tile(2, 1'b1, 1'b0, 1'b0);
        drain_tile(1'b1, -1);

        load_tile(COL_NUM, 1'b0, 1'b0, 1'b0);
        drain_start = 1'b1;
        skew_mode   = 1'b1;
        step();
        drain_start = 1'b0;
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        check_idle("arst_drain");
        @(negedge clk);
        reset = 1'b1;
        step();

        repeat (8) begin
            n   = $urandom_range(1, COL_NUM);
            lst = (n < COL_NUM) ? 1'b1 : 1'($urandom_range(0, 1));
            load_tile(n, lst, 1'b1, 1'b0);
            drain_tile(1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
